// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, sensor register map and default device address.
package i2c_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CFG      = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;

  // Read-side register map of the emulated sensor.
  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [15:0] shadow,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  id);
    case (ptr)
      REG_TEMP_MSB: reg_read = shadow[15:8];
      REG_TEMP_LSB: reg_read = shadow[7:0];
      REG_CFG:      reg_read = cfg;
      REG_ID:       reg_read = id;
      default:      reg_read = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] meta, [1] sync, [2] history; reset to the idle-high bus level
  logic [2:0] r_scl_pipe;
  logic [2:0] r_sda_pipe;
  logic       w_scl_high;

  assign w_scl_high = r_scl_pipe[1] & r_scl_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_pipe <= 3'b111;
      r_sda_pipe <= 3'b111;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      sda_s      <= 1'b1;
    end else begin
      r_scl_pipe <= {r_scl_pipe[1:0], scl};
      r_sda_pipe <= {r_sda_pipe[1:0], sda};
      scl_rise   <= r_scl_pipe[1] & ~r_scl_pipe[2];
      scl_fall   <= ~r_scl_pipe[1] & r_scl_pipe[2];
      start_det  <= w_scl_high & r_sda_pipe[2] & ~r_sda_pipe[1];
      stop_det   <= w_scl_high & ~r_sda_pipe[2] & r_sda_pipe[1];
      sda_s      <= r_sda_pipe[1];
    end
  end

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// I2C target emulating the polled temperature sensor: pointer register, temp/ID/config reads,
// config write with a one-clock strobe.
module i2c_temp_sensor_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter logic [7:0] ID_VALUE  = 8'hCB,
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_value,
  output logic [7:0]  cfg_reg,
  output logic        cfg_wr,
  output logic        busy
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]         r_shift, w_shift_nxt;
  logic [7:0]         r_ptr, w_ptr_nxt;
  logic [7:0]         r_tx, w_tx_nxt;
  logic [7:0]         r_cfg, w_cfg_nxt;
  logic [15:0]        r_shadow, w_shadow_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_sda_low, w_sda_low_nxt;
  logic               r_cfg_wr, w_cfg_wr_nxt;
  logic               r_busy, w_busy_nxt;
  logic [7:0]         w_byte;
  logic [7:0]         w_rd_byte;

  assign w_byte    = {r_shift, w_sda_s};
  // The shadow is loaded on the same edge as the first read byte, so bypass it then.
  assign w_rd_byte = reg_read(r_ptr, (r_state == ST_ADDR_ACK) ? temp_value : r_shadow,
                              r_cfg, ID_VALUE);

  assign sda     = r_sda_low ? 1'b0 : 1'bz;
  assign cfg_reg = r_cfg;
  assign cfg_wr  = r_cfg_wr;
  assign busy    = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd7;
      r_shift   <= 7'h00;
      r_ptr     <= 8'h00;
      r_tx      <= 8'h00;
      r_cfg     <= CFG_RESET;
      r_shadow  <= 16'h0000;
      r_rw      <= 1'b0;
      r_phase   <= 1'b0;
      r_sda_low <= 1'b0;
      r_cfg_wr  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_tx      <= w_tx_nxt;
      r_cfg     <= w_cfg_nxt;
      r_shadow  <= w_shadow_nxt;
      r_rw      <= w_rw_nxt;
      r_phase   <= w_phase_nxt;
      r_sda_low <= w_sda_low_nxt;
      r_cfg_wr  <= w_cfg_wr_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_tx_nxt      = r_tx;
    w_cfg_nxt     = r_cfg;
    w_shadow_nxt  = r_shadow;
    w_rw_nxt      = r_rw;
    w_phase_nxt   = r_phase;
    w_sda_low_nxt = r_sda_low;
    w_cfg_wr_nxt  = 1'b0;
    w_busy_nxt    = r_busy;

    if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = 3'd7;
      w_phase_nxt   = 1'b0;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b1;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_phase_nxt   = 1'b0;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            // Decrement wraps 0 -> 7, leaving the counter ready for the next byte.
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
            if (r_bit_cnt == 3'd0) begin
              w_phase_nxt = 1'b0;
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  w_state_nxt = ST_ADDR_ACK;
                  w_rw_nxt    = w_byte[0];
                end else begin
                  w_state_nxt = ST_IDLE;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_nxt   = w_byte;
                w_state_nxt = ST_PTR_ACK;
              end else begin
                if (r_ptr == REG_CFG) begin
                  w_cfg_nxt    = w_byte;
                  w_cfg_wr_nxt = 1'b1;
                end
                w_ptr_nxt   = r_ptr + 8'd1;
                w_state_nxt = ST_WDATA_ACK;
              end
            end
          end
        end

        // First falling edge pulls sda low, second releases it and moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_low_nxt = 1'b1;
              w_phase_nxt   = 1'b1;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_phase_nxt   = 1'b0;
              w_bit_cnt_nxt = 3'd7;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_shadow_nxt  = temp_value;
                w_tx_nxt      = w_rd_byte;
                w_sda_low_nxt = ~w_rd_byte[7];
                w_state_nxt   = ST_RDATA;
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = ST_PTR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
            if (r_bit_cnt == 3'd0) begin
              w_ptr_nxt   = r_ptr + 8'd1;
              w_phase_nxt = 1'b0;
              w_state_nxt = ST_RDATA_ACK;
            end
          end else if (w_scl_fall) begin
            w_sda_low_nxt = ~r_tx[r_bit_cnt];
          end
        end

        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_s) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_low_nxt = 1'b0;
            end else begin
              w_tx_nxt      = w_rd_byte;
              w_sda_low_nxt = ~w_rd_byte[7];
              w_bit_cnt_nxt = 3'd7;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = ST_RDATA;
            end
          end
        end

        ST_IDLE: begin
          w_sda_low_nxt = 1'b0;
        end

        default: begin
          w_state_nxt   = ST_IDLE;
          w_sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_sensor_slave.sv
// Bench for i2c_temp_sensor_slave: bit-banged I2C master against a register-map model of the sensor.
`timescale 1ns/1ps
module tb_i2c_temp_sensor_slave;

  localparam int unsigned Q   = 50;
  localparam logic [6:0]  DEV = 7'h4B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_low;
  logic [15:0] temp_value;
  logic [7:0]  cfg_reg;
  logic        cfg_wr;
  logic        busy;
  wire         sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_temp_sensor_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda        (sda),
    .temp_value (temp_value),
    .cfg_reg    (cfg_reg),
    .cfg_wr     (cfg_wr),
    .busy       (busy)
  );

  // Clocks where the target pulls sda low, and clocks with cfg_wr high.
  int unsigned dut_low_cnt = 0;
  int unsigned cfg_wr_cnt  = 0;
  always @(posedge clk) begin
    if (!m_low && sda == 1'b0) dut_low_cnt++;
    if (cfg_wr) cfg_wr_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sensor model: pointer, config and temperature snapshot.
  logic [7:0]  md_ptr;
  logic [7:0]  md_cfg;
  logic [15:0] md_shadow;

  function automatic logic [7:0] md_reg(input logic [7:0] a);
    case (a)
      8'h00:   return md_shadow[15:8];
      8'h01:   return md_shadow[7:0];
      8'h03:   return md_cfg;
      8'h0B:   return 8'hCB;
      default: return 8'h00;
    endcase
  endfunction

  task automatic bus_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_low = ~b; #Q; scl = 1'b1; #Q; s = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  task automatic xfer_write(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                            input int nbytes, input logic do_stop);
    logic       ack;
    logic [7:0] d;
    bus_start;
    wr_byte({DEV, 1'b0}, ack);
    check_val("waddr_ack", 16'(ack), 16'd1);
    wr_byte(ptr, ack);
    check_val("ptr_ack", 16'(ack), 16'd1);
    md_ptr = ptr;
    for (int k = 0; k < nbytes; k++) begin
      d = (k == 0) ? d0 : d1;
      wr_byte(d, ack);
      check_val("wdata_ack", 16'(ack), 16'd1);
      if (md_ptr == 8'h03) md_cfg = d;
      md_ptr = md_ptr + 8'd1;
    end
    if (do_stop) bus_stop;
  endtask

  task automatic xfer_read(input int nbytes, input logic chg, input logic [15:0] new_temp);
    logic       ack;
    logic [7:0] d;
    bus_start;
    wr_byte({DEV, 1'b1}, ack);
    check_val("raddr_ack", 16'(ack), 16'd1);
    md_shadow = temp_value;
    for (int k = 0; k < nbytes; k++) begin
      rd_byte(k == nbytes - 1, d);
      check_val("rdata", 16'(d), 16'(md_reg(md_ptr)));
      md_ptr = md_ptr + 8'd1;
      if (chg && k == 0) temp_value = new_temp;
    end
    bus_stop;
  endtask

  logic [7:0] ptr_tab [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0B, 8'hFE, 8'hFF, 8'h10};

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack;
    logic        s;
    int unsigned snap;
    logic [7:0]  ptr;
    logic [6:0]  bad;

    rst_n      = 1'b0;
    scl        = 1'b1;
    m_low      = 1'b0;
    temp_value = 16'h0000;
    md_ptr     = 8'h00;
    md_cfg     = 8'h00;
    md_shadow  = 16'h0000;
    repeat (4) @(negedge clk);
    check_val("rst_sda", 16'(sda), 16'd1);
    check_val("rst_cfg", 16'(cfg_reg), 16'h00);
    check_val("rst_cfg_wr", 16'(cfg_wr), 16'd0);
    check_val("rst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ID read via pointer write and repeated START
    bus_start;
    check_val("busy_start", 16'(busy), 16'd1);
    wr_byte(8'h96, ack);
    check_val("id_waddr_ack", 16'(ack), 16'd1);
    wr_byte(8'h0B, ack);
    check_val("id_ptr_ack", 16'(ack), 16'd1);
    md_ptr = 8'h0B;
    xfer_read(1, 1'b0, 16'h0);
    check_val("id_busy_stop", 16'(busy), 16'd0);
    check_val("id_sda_rel", 16'(sda), 16'd1);

    // Temperature read stays coherent when temp_value changes mid-read
    temp_value = 16'h0C80;
    xfer_write(8'h00, 8'h00, 8'h00, 0, 1'b0);
    xfer_read(2, 1'b1, 16'h0D00);

    // Wrong address: never acknowledged, sda never driven
    snap = dut_low_cnt;
    bus_start;
    wr_byte(8'h90, ack);
    check_val("bad_addr_nack", 16'(ack), 16'd0);
    wr_byte(8'h03, ack);
    check_val("bad_ptr_nack", 16'(ack), 16'd0);
    wr_byte(8'h5A, ack);
    check_val("bad_busy", 16'(busy), 16'd1);
    bus_stop;
    check_val("bad_sda_quiet", 16'(dut_low_cnt - snap), 16'd0);
    check_val("bad_cfg", 16'(cfg_reg), 16'(md_cfg));

    // Config write strobe and readback
    snap = cfg_wr_cnt;
    xfer_write(8'h03, 8'hA5, 8'h00, 1, 1'b1);
    check_val("cfg_val", 16'(cfg_reg), 16'hA5);
    check_val("cfg_wr_pulse", 16'(cfg_wr_cnt - snap), 16'd1);
    xfer_write(8'h03, 8'h00, 8'h00, 0, 1'b0);
    xfer_read(1, 1'b0, 16'h0);

    // Pointer wrap 0xFF -> 0x00
    temp_value = 16'h0000;
    xfer_write(8'hFF, 8'h00, 8'h00, 0, 1'b0);
    xfer_read(2, 1'b0, 16'h0);

    // STOP inside a data byte discards it
    snap = cfg_wr_cnt;
    xfer_write(8'h03, 8'h00, 8'h00, 0, 1'b0);
    for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
    bus_stop;
    check_val("part_cfg", 16'(cfg_reg), 16'(md_cfg));
    check_val("part_no_wr", 16'(cfg_wr_cnt - snap), 16'd0);
    check_val("part_busy", 16'(busy), 16'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      temp_value = 16'($urandom);
      ptr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ptr_tab[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: begin
          xfer_write(ptr, 8'($urandom), 8'($urandom), $urandom_range(0, 2), 1'b1);
          check_val("rnd_cfg", 16'(cfg_reg), 16'(md_cfg));
        end
        1: begin
          xfer_write(ptr, 8'h00, 8'h00, 0, 1'b0);
          xfer_read($urandom_range(1, 3), 1'b0, 16'h0);
        end
        2: xfer_read($urandom_range(1, 3), 1'b1, 16'($urandom));
        default: begin
          bad = 7'($urandom);
          if (bad == DEV) bad = bad ^ 7'h01;
          bus_start;
          wr_byte({bad, 1'($urandom)}, ack);
          check_val("rnd_bad_nack", 16'(ack), 16'd0);
          bus_stop;
          check_val("rnd_bad_cfg", 16'(cfg_reg), 16'(md_cfg));
        end
      endcase
    end

    // Reset while the target drives a 0 data bit releases sda at once
    xfer_write(8'h03, 8'h5A, 8'h00, 1, 1'b1);
    xfer_write(8'h02, 8'h00, 8'h00, 0, 1'b0);
    bus_start;
    wr_byte({DEV, 1'b1}, ack);
    check_val("rst_pre_ack", 16'(ack), 16'd1);
    check_val("rst_pre_drive", 16'(sda), 16'd0);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_sda", 16'(sda), 16'd1);
    check_val("rst_mid_cfg", 16'(cfg_reg), 16'h00);
    check_val("rst_mid_busy", 16'(busy), 16'd0);
    #Q;
    scl   = 1'b1;
    m_low = 1'b0;
    #Q;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
